// File: rtl/gray_pkg.sv
// Gray-code helpers shared by counters and CDC pointer synchronisers.
// Latency: pure functions, no state.
// Backpressure: not applicable.
package gray_pkg;

  localparam int GRAY_MIN_WIDTH = 4;
  localparam int GRAY_MAX_WIDTH = 64;

  // Binary to Gray: each bit is the XOR of itself and its left neighbour.
  function automatic logic [63:0] bin2gray(input logic [63:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  // Narrower values are zero-extended by the caller, which leaves the low bits exact.
  function automatic logic [63:0] gray2bin(input logic [63:0] g);
    logic [63:0] b;
    b[63] = g[63];
    for (int i = 62; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Parity of a Gray code equals the LSB of its binary value.
  function automatic logic gray_parity(input logic [63:0] g);
    return ^g;
  endfunction

endpackage

// File: rtl/gray_step.sv
// One natural Gray-code step (up or down) driven by the hidden parity bit.
// Latency: combinational.
// Backpressure: none; the caller decides whether to commit the result.
module gray_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             parity,
  input  logic             up,
  output logic [WIDTH-1:0] nxt,
  output logic             nat_wrap
);

  // Isolate the lowest set bit as a one-hot mask (cur & -cur).
  logic [WIDTH-1:0] low_set;
  assign low_set = cur & (~cur + WIDTH'(1));

  // Even parity going up (odd going down) flips bit0; otherwise flip the bit left of the
  // lowest set bit. A lowest set bit at the MSB only occurs at the natural max going up,
  // where flipping the MSB itself rolls over to zero.
  always_comb begin
    nxt      = cur;
    nat_wrap = 1'b0;
    if (up ^ parity) begin
      nxt = cur ^ WIDTH'(1);
    end else if (low_set[WIDTH-1]) begin
      nxt      = cur ^ low_set;
      nat_wrap = up;
    end else begin
      nxt = cur ^ (low_set << 1);
    end
  end

endmodule

// File: rtl/gray_updown_counter.sv
// Native Gray up/down counter with programmable wrap point, sync load and wrap pulse.
// Latency: one cycle from rst/load/enable to cnt and wrap.
// Backpressure: none; steps on every enabled cycle. GRAY_CNT_BIN_OUT_EN adds the cnt_bin port.
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  input  logic [WIDTH-1:0] wrap_gray,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
`ifdef GRAY_CNT_BIN_OUT_EN
  ,
  output logic [WIDTH-1:0] cnt_bin
`else
`endif
);

  if (WIDTH < GRAY_MIN_WIDTH || WIDTH > GRAY_MAX_WIDTH) begin : g_width_check
    $error("gray_updown_counter: WIDTH %0d outside supported range 4..64", WIDTH);
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             parity_q, parity_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] step_nxt;
  logic             step_wrap;

  gray_step #(.WIDTH(WIDTH)) u_step (
    .cur      (cnt_q),
    .parity   (parity_q),
    .up       (up),
    .nxt      (step_nxt),
    .nat_wrap (step_wrap)
  );

  // Next state: load beats enable; the terminal compares beat the natural step.
  always_comb begin
    cnt_d    = cnt_q;
    parity_d = parity_q;
    wrap_d   = 1'b0;
    if (load) begin
      cnt_d    = load_gray;
      parity_d = gray_parity(64'(load_gray));
    end else if (enable) begin
      if (up && (cnt_q == wrap_gray)) begin
        cnt_d    = '0;
        parity_d = 1'b0;
        wrap_d   = 1'b1;
      end else if (!up && (cnt_q == '0)) begin
        cnt_d    = wrap_gray;
        parity_d = gray_parity(64'(wrap_gray));
        wrap_d   = 1'b1;
      end else begin
        cnt_d    = step_nxt;
        wrap_d   = step_wrap;
        parity_d = step_wrap ? gray_parity(64'(step_nxt)) : ~parity_q;
      end
    end
  end

  // State registers with synchronous reset to the configured Gray value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= RESET_VALUE;
      parity_q <= gray_parity(64'(RESET_VALUE));
      wrap_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      parity_q <= parity_d;
      wrap_q   <= wrap_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = wrap_q;

`ifdef GRAY_CNT_BIN_OUT_EN
  assign cnt_bin = WIDTH'(gray2bin(64'(cnt_q)));
`else
`endif

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed bench for the 4-bit Gray up/down counter.
// Latency: results sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_gray_updown_counter;

  logic       clk = 1'b0;
  logic       rst, enable, up, load;
  logic [3:0] load_gray, wrap_gray;
  logic [3:0] cnt0, cnt1;
  logic       wrap0, wrap1;
`ifdef GRAY_CNT_BIN_OUT_EN
  logic [3:0] cnt_bin0, cnt_bin1;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0] gseq [16];
  logic [3:0] prev;

  always #5 clk = ~clk;

  gray_updown_counter #(.WIDTH(4), .RESET_VALUE(4'b0000)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .up(up), .load(load),
    .load_gray(load_gray), .wrap_gray(wrap_gray), .cnt(cnt0), .wrap(wrap0)
`ifdef GRAY_CNT_BIN_OUT_EN
    , .cnt_bin(cnt_bin0)
`endif
  );

  gray_updown_counter #(.WIDTH(4), .RESET_VALUE(4'b0011)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .up(up), .load(load),
    .load_gray(load_gray), .wrap_gray(wrap_gray), .cnt(cnt1), .wrap(wrap1)
`ifdef GRAY_CNT_BIN_OUT_EN
    , .cnt_bin(cnt_bin1)
`endif
  );

  function automatic logic [3:0] tb_g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
`ifdef GRAY_CNT_BIN_OUT_EN
    chk("cnt_bin0", 64'(cnt_bin0), 64'(tb_g2b(cnt0)));
    chk("cnt_bin1", 64'(cnt_bin1), 64'(tb_g2b(cnt1)));
`endif
  endtask

  initial begin
    gseq[0]  = 4'b0000; gseq[1]  = 4'b0001; gseq[2]  = 4'b0011; gseq[3]  = 4'b0010;
    gseq[4]  = 4'b0110; gseq[5]  = 4'b0111; gseq[6]  = 4'b0101; gseq[7]  = 4'b0100;
    gseq[8]  = 4'b1100; gseq[9]  = 4'b1101; gseq[10] = 4'b1111; gseq[11] = 4'b1110;
    gseq[12] = 4'b1010; gseq[13] = 4'b1011; gseq[14] = 4'b1001; gseq[15] = 4'b1000;

    rst = 1'b1; enable = 1'b0; up = 1'b1; load = 1'b0;
    load_gray = 4'b0000; wrap_gray = 4'b1000;
    #1;
    step();
    chk("rst_cnt0", 64'(cnt0), 64'h0);
    chk("rst_wrap0", 64'(wrap0), 64'h0);
    chk("rst_cnt1", 64'(cnt1), 64'h3);

    // Full-range count up, natural rollover.
    rst = 1'b0; enable = 1'b1; up = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      prev = cnt0;
      step();
      chk("full_cnt", 64'(cnt0), 64'(gseq[i % 16]));
      chk("full_wrap", 64'(wrap0), 64'(i == 16));
      chk("full_onebit", 64'($countones(prev ^ cnt0)), 64'd1);
    end

    // Modulus 10.
    wrap_gray = 4'b1101;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("mod10_cnt", 64'(cnt0), 64'(gseq[i % 10]));
      chk("mod10_wrap", 64'(wrap0), 64'((i % 10) == 0));
    end

    // Down from zero wraps to the terminal value, then counts down by one.
    up = 1'b0;
    step();
    chk("down_cnt", 64'(cnt0), 64'(4'b1101));
    chk("down_wrap", 64'(wrap0), 64'h1);
    for (int k = 8; k >= 5; k--) begin
      prev = cnt0;
      step();
      chk("down_cnt", 64'(cnt0), 64'(gseq[k]));
      chk("down_dec", 64'(tb_g2b(prev) - tb_g2b(cnt0)), 64'd1);
      chk("down_wrap", 64'(wrap0), 64'h0);
    end

    // Load wins over enable.
    load = 1'b1; load_gray = 4'b0110; up = 1'b1;
    step();
    chk("load_cnt", 64'(cnt0), 64'(4'b0110));
    chk("load_wrap", 64'(wrap0), 64'h0);
    load = 1'b0;
    step();
    chk("load_up", 64'(cnt0), 64'(4'b0111));
    up = 1'b0;
    step();
    chk("load_down", 64'(cnt0), 64'(4'b0110));

    // Loaded above the terminal value: runs on to the natural rollover.
    load = 1'b1; load_gray = 4'b1110; up = 1'b1;
    step();
    load = 1'b0;
    for (int k = 12; k <= 16; k++) begin
      step();
      chk("above_cnt", 64'(cnt0), 64'(gseq[k % 16]));
      chk("above_wrap", 64'(wrap0), 64'(k == 16));
    end

    // Reset mid-count with enable high.
    load = 1'b1; load_gray = 4'b0110;
    step();
    load = 1'b0;
    step();
    step();
    chk("pre_rst_cnt", 64'(cnt0), 64'(4'b0101));
    rst = 1'b1;
    step();
    chk("mid_rst_cnt0", 64'(cnt0), 64'h0);
    chk("mid_rst_wrap0", 64'(wrap0), 64'h0);
    chk("mid_rst_cnt1", 64'(cnt1), 64'(4'b0011));
    rst = 1'b0;
    step();
    chk("rst_up_cnt0", 64'(cnt0), 64'(4'b0001));
    chk("rst_up_cnt1", 64'(cnt1), 64'(4'b0010));

    // Hold.
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_cnt", 64'(cnt0), 64'(4'b0001));
      chk("hold_wrap", 64'(wrap0), 64'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
